// File: rtl/counter_checker_pkg.sv
// counter_checker_pkg
//   Shared definitions for the counter stream checker.
//   - mode encodings reported on counter_checker.mode
//   - bit positions of the per-step mode mask {GD, GU, D, U}
//   - tracker state enum
//   - helpers for the candidate mask (one-hot test, index of a bit)
package counter_checker_pkg;

  localparam logic [1:0] MODE_BUP = 2'b00;
  localparam logic [1:0] MODE_BDN = 2'b01;
  localparam logic [1:0] MODE_GUP = 2'b10;
  localparam logic [1:0] MODE_GDN = 2'b11;

  // Mask bit i corresponds to mode encoding i.
  localparam int BIT_BUP = 0;
  localparam int BIT_BDN = 1;
  localparam int BIT_GUP = 2;
  localparam int BIT_GDN = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  function automatic logic is_onehot(input logic [3:0] m);
    return (m != 4'd0) && ((m & (m - 4'd1)) == 4'd0);
  endfunction

  // Index of the highest set bit; only meaningful for a one-hot mask.
  function automatic logic [1:0] mask_index(input logic [3:0] m);
    logic [1:0] idx;
    idx = MODE_BUP;
    if (m[BIT_BDN]) idx = MODE_BDN;
    if (m[BIT_GUP]) idx = MODE_GUP;
    if (m[BIT_GDN]) idx = MODE_GDN;
    return idx;
  endfunction

endpackage

// File: rtl/counter_checker_gray2bin.sv
// gray2bin
//   Purely combinational reflected-Gray to binary converter.
//   Ports:
//     gray  in  N  Gray-coded value
//     bin   out N  binary equivalent (bin[i] = XOR of gray[N-1:i])
module gray2bin #(
  parameter int N = 4
) (
  input  logic [N-1:0] gray,
  output logic [N-1:0] bin
);

  for (genvar i = 0; i < N; i++) begin : g_bit
    assign bin[i] = ^gray[N-1:i];
  end

endmodule

// File: rtl/counter_checker.sv
// counter_checker
//   Monitors an N-bit count stream and works out which mode drives it:
//   binary up, binary down, Gray up or Gray down. Narrows a candidate mask
//   over consecutive non-hold steps, locks once a single mode has survived
//   LOCK steps, and flags/counts sequence breaks.
//   Optional feature: define COUNTER_CHECKER_EXPECT_EN to add ctrl_exp
//   (expected mode) and mismatch; a change of ctrl_exp forces a relock
//   without counting an error.
//   Ports:
//     clk        in   1     clock, posedge
//     reset      in   1     synchronous, active-low
//     en         in   1     sample enable; low = ignore cnt_in, hold state
//     cnt_in     in   N     observed count value
//     ctrl_exp   in   2     expected mode (COUNTER_CHECKER_EXPECT_EN only)
//     mode       out  2     detected mode (see counter_checker_pkg)
//     locked     out  1     mode is valid and stable
//     err        out  1     one-cycle pulse on a sequence break
//     err_cnt    out  ERRW  saturating count of err pulses
//     mismatch   out  1     locked with mode != ctrl_exp (COUNTER_CHECKER_EXPECT_EN only)
//     dbg_state  out  2     current tracker state (state_t encoding)
//   Handshake: none; each cycle with en=1 is one accepted sample, and its
//   effect is visible on the registered outputs after that clock edge.
module counter_checker
  import counter_checker_pkg::*;
#(
  parameter int N    = 4,
  parameter int LOCK = 4,
  parameter int ERRW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic [N-1:0]    cnt_in,
`ifdef COUNTER_CHECKER_EXPECT_EN
  input  logic [1:0]      ctrl_exp,
`endif
  output logic [1:0]      mode,
  output logic            locked,
  output logic            err,
  output logic [ERRW-1:0] err_cnt,
`ifdef COUNTER_CHECKER_EXPECT_EN
  output logic            mismatch,
`endif
  output logic [1:0]      dbg_state
);

  localparam int RW = $clog2(LOCK + 1);
  localparam logic [RW-1:0] LOCK_V = RW'(LOCK);

  state_t            state, state_d;
  logic [1:0]        mode_d;
  logic              locked_d, err_d;
  logic [ERRW-1:0]   err_cnt_d, err_cnt_inc;
  logic [3:0]        cand, cand_d;
  logic [RW-1:0]     run, run_d, run_inc;
  logic [N-1:0]      prev, prev_d;
  logic [N-1:0]      bin_c, bin_p;
  logic [3:0]        s, x, restart_cand;
  logic [RW-1:0]     restart_run;
  logic              hold;

  gray2bin #(.N(N)) u_g2b_c (.gray(cnt_in), .bin(bin_c));
  gray2bin #(.N(N)) u_g2b_p (.gray(prev),   .bin(bin_p));

  // Step classifier; all arithmetic wraps mod 2^N.
  assign s[BIT_BUP] = (cnt_in == prev + N'(1));
  assign s[BIT_BDN] = (cnt_in == prev - N'(1));
  assign s[BIT_GUP] = (bin_c == bin_p + N'(1));
  assign s[BIT_GDN] = (bin_c == bin_p - N'(1));
  assign hold       = (cnt_in == prev);
  assign x          = cand & s;

  // After a break, restart from whatever this step itself supports.
  assign restart_cand = (s == 4'd0) ? 4'hF : s;
  assign restart_run  = (s == 4'd0) ? '0 : RW'(1);
  assign run_inc      = (run >= LOCK_V) ? run : run + RW'(1);
  assign err_cnt_inc  = (err_cnt == '1) ? err_cnt : err_cnt + ERRW'(1);

`ifdef COUNTER_CHECKER_EXPECT_EN
  logic [1:0] ctrl_q;
  logic       mismatch_d;
`endif

  always_comb begin
    state_d   = state;
    mode_d    = mode;
    locked_d  = locked;
    err_d     = 1'b0;
    err_cnt_d = err_cnt;
    cand_d    = cand;
    run_d     = run;
    prev_d    = prev;
    if (en) begin
      prev_d = cnt_in;
      case (state)
        ST_IDLE: state_d = ST_TRACK;
        ST_TRACK: begin
          if (!hold) begin
            if (x != 4'd0) begin
              cand_d = x;
              run_d  = run_inc;
              if (is_onehot(x) && (run_inc >= LOCK_V)) begin
                state_d  = ST_LOCKED;
                mode_d   = mask_index(x);
                locked_d = 1'b1;
              end
            end else begin
              err_d     = 1'b1;
              err_cnt_d = err_cnt_inc;
              cand_d    = restart_cand;
              run_d     = restart_run;
            end
          end
        end
        ST_LOCKED: begin
          if (!hold && !s[mode]) begin
            err_d     = 1'b1;
            err_cnt_d = err_cnt_inc;
            locked_d  = 1'b0;
            cand_d    = restart_cand;
            run_d     = restart_run;
            state_d   = ST_TRACK;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
`ifdef COUNTER_CHECKER_EXPECT_EN
    // A new expected mode invalidates the current lock; this is not a break.
    if (state == ST_LOCKED && ctrl_exp != ctrl_q) begin
      state_d   = ST_TRACK;
      locked_d  = 1'b0;
      cand_d    = 4'hF;
      run_d     = '0;
      err_d     = 1'b0;
      err_cnt_d = err_cnt;
    end
    mismatch_d = locked && (mode != ctrl_exp);
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= ST_IDLE;
      mode    <= MODE_BUP;
      locked  <= 1'b0;
      err     <= 1'b0;
      err_cnt <= '0;
      cand    <= 4'hF;
      run     <= '0;
      prev    <= '0;
    end else begin
      state   <= state_d;
      mode    <= mode_d;
      locked  <= locked_d;
      err     <= err_d;
      err_cnt <= err_cnt_d;
      cand    <= cand_d;
      run     <= run_d;
      prev    <= prev_d;
    end
  end

`ifdef COUNTER_CHECKER_EXPECT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      ctrl_q   <= 2'b00;
      mismatch <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_exp;
      mismatch <= mismatch_d;
    end
  end
`endif

  assign dbg_state = state;

endmodule

// File: tb/tb_counter_checker.sv
module tb_counter_checker;
  import counter_checker_pkg::*;

  localparam int N    = 4;
  localparam int LOCK = 4;
  localparam int ERRW = 8;
  localparam int W    = 12;   // {err, locked, mode, err_cnt}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic en = 1'b0;
  logic [N-1:0] cnt_in = '0;
  logic [1:0] mode;
  logic locked, err;
  logic [ERRW-1:0] err_cnt;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  counter_checker #(.N(N), .LOCK(LOCK), .ERRW(ERRW)) dut (
    .clk(clk), .reset(reset), .en(en), .cnt_in(cnt_in),
    .mode(mode), .locked(locked), .err(err), .err_cnt(err_cnt),
    .dbg_state(dbg_state)
  );

  int total = 0;
  int bad = 0;
  logic chk_on = 1'b0;
  logic [W-1:0] exp_q[$];

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each mode is described by "what value must come next", using Gray
  // encoding and a search for decoding.
  function automatic int g_enc(input int b);
    return (b ^ (b >> 1)) & 15;
  endfunction

  function automatic int g_dec(input int g);
    for (int b = 0; b < 16; b++) if (g_enc(b) == g) return b;
    return 0;
  endfunction

  function automatic bit follows(input int m, input int p, input int c);
    case (m)
      0: return c == (p + 1) % 16;
      1: return c == (p + 15) % 16;
      2: return g_dec(c) == (g_dec(p) + 1) % 16;
      default: return g_dec(c) == (g_dec(p) + 15) % 16;
    endcase
  endfunction

  int m_phase = 0;            // 0 idle, 1 tracking, 2 locked
  bit m_alive[4];
  int m_run = 0, m_mode = 0, m_ec = 0, m_prev = 0;
  bit m_locked = 0, m_err = 0;

  task automatic m_break(input bit ok[4]);
    int k;
    k = 0;
    m_err = 1;
    if (m_ec < 255) m_ec++;
    for (int m = 0; m < 4; m++) k += ok[m];
    for (int m = 0; m < 4; m++) m_alive[m] = (k == 0) ? 1'b1 : ok[m];
    m_run = (k == 0) ? 0 : 1;
  endtask

  always @(posedge clk) begin
    bit ok[4];
    int c, n, last;
    c = int'(cnt_in);
    m_err = 0;
    if (!reset) begin
      m_phase = 0; m_run = 0; m_mode = 0; m_ec = 0; m_prev = 0; m_locked = 0;
      for (int m = 0; m < 4; m++) m_alive[m] = 1;
    end else if (en) begin
      if (m_phase == 0) begin
        m_phase = 1;
      end else if (c != m_prev) begin
        for (int m = 0; m < 4; m++) ok[m] = follows(m, m_prev, c);
        if (m_phase == 1) begin
          n = 0; last = 0;
          for (int m = 0; m < 4; m++) if (m_alive[m] && ok[m]) begin n++; last = m; end
          if (n > 0) begin
            for (int m = 0; m < 4; m++) m_alive[m] = m_alive[m] && ok[m];
            if (m_run < LOCK) m_run++;
            if (n == 1 && m_run >= LOCK) begin
              m_phase = 2; m_mode = last; m_locked = 1;
            end
          end else m_break(ok);
        end else if (!ok[m_mode]) begin
          m_break(ok);
          m_locked = 0;
          m_phase = 1;
        end
      end
      m_prev = c;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_on) begin
      cmp("err", 32'(err), 32'(m_err));
      cmp("locked", 32'(locked), 32'(m_locked));
      cmp("mode", 32'(mode), 32'(m_mode));
      cmp("err_cnt", 32'(err_cnt), 32'(m_ec));
      cmp("state", 32'(dbg_state),
          32'((m_phase == 0) ? ST_IDLE : (m_phase == 1) ? ST_TRACK : ST_LOCKED));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic e, input logic [N-1:0] v);
    @(posedge clk);
    #1;
    en = e;
    cnt_in = v;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Let the last driven sample be taken, then check hand-computed values
  // against both the DUT and the model.
  task automatic lit(input string nm, input logic e, input logic lk,
                     input logic [1:0] md, input logic [7:0] ec);
    logic [W-1:0] want;
    exp_q.push_back({e, lk, md, ec});
    drive(1'b0, cnt_in);
    @(negedge clk);
    want = exp_q.pop_front();
    cmp(nm, 32'({err, locked, mode, err_cnt}), 32'(want));
    cmp({nm, "_model"}, 32'({m_err, m_locked, 2'(m_mode), 8'(m_ec)}), 32'(want));
  endtask

  task automatic play(input int n, input int v0, input int v1, input int v2,
                      input int v3, input int v4, input int v5, input int v6);
    int v[7];
    v = '{v0, v1, v2, v3, v4, v5, v6};
    for (int i = 0; i < n; i++) drive(1'b1, 4'(v[i]));
  endtask

  initial begin
    // reset state
    do_reset();
    chk_on = 1'b1;
    @(negedge clk);
    cmp("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    cmp("rst_outs", 32'({err, locked, mode, err_cnt}), 32'(0));

    // binary up: lock after 4th step
    play(6, 0, 1, 2, 3, 4, 5, 0);
    lit("bup_lock", 1'b0, 1'b1, 2'b00, 8'd0);

    // Gray up
    do_reset();
    play(7, 0, 1, 3, 2, 6, 7, 5);
    lit("gup_lock", 1'b0, 1'b1, 2'b10, 8'd0);

    // binary down across the wrap
    do_reset();
    play(6, 2, 1, 0, 15, 14, 13, 0);
    lit("bdn_lock", 1'b0, 1'b1, 2'b01, 8'd0);

    // break while locked, then relock
    do_reset();
    play(7, 0, 1, 2, 3, 4, 5, 6);
    drive(1'b1, 4'd9);
    lit("break_err", 1'b1, 1'b0, 2'b00, 8'd1);
    play(4, 10, 11, 12, 13, 0, 0, 0);
    lit("relock", 1'b0, 1'b1, 2'b00, 8'd1);

    // holds and enable gap do not advance the lock
    do_reset();
    play(6, 0, 1, 2, 3, 3, 3, 0);
    for (int i = 0; i < 5; i++) drive(1'b0, 4'($urandom_range(0, 15)));
    drive(1'b0, 4'd3);
    lit("hold_nolock", 1'b0, 1'b0, 2'b00, 8'd0);
    drive(1'b1, 4'd4);
    lit("hold_lock", 1'b0, 1'b1, 2'b00, 8'd0);

    // two errors, relock, then reset while locked
    drive(1'b1, 4'd9);
    drive(1'b1, 4'd0);
    play(4, 1, 2, 3, 4, 0, 0, 0);
    lit("two_err", 1'b0, 1'b1, 2'b00, 8'd2);
    do_reset();
    @(negedge clk);
    cmp("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    cmp("mid_rst_outs", 32'({err, locked, mode, err_cnt}), 32'(0));
    drive(1'b1, 4'd7);
    lit("first_after_rst", 1'b0, 1'b0, 2'b00, 8'd0);
    cmp("first_state", 32'(dbg_state), 32'(ST_TRACK));

    // error counter saturation; err keeps pulsing
    do_reset();
    drive(1'b1, 4'd0);
    for (int i = 0; i < 300; i++) drive(1'b1, (i % 2 == 0) ? 4'd5 : 4'd0);
    lit("sat", 1'b1, 1'b0, 2'b00, 8'd255);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
